rv_issue_ctrl: RTL and testbench

RV_ISSUE_CTRL -- requirements
Module: rv_issue_ctrl

---
 rtl/rv_pkg.sv | 25 ++
 rtl/rv_scbd_cnt.sv | 52 +++++
 rtl/rv_issue_ctrl.sv | 116 +++++++++++
 tb/tb_rv_issue_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the issue controller and its pending-write scoreboard.
//   NREG    : architectural registers tracked (x0 included, never pending)
//   PEND_W  : per-register in-flight write counter width
//   IDX_W   : register index width
//   state_e : issue FSM states
//   reg_upd_t : one scoreboard counter update (valid + register index)
package rv_pkg;

  localparam int NREG   = 32;
  localparam int PEND_W = 2;
  localparam int IDX_W  = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LONGWAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } reg_upd_t;

endpackage

// File: rtl/rv_scbd_cnt.sv
// Pending-write scoreboard: one saturating up/down counter per register.
//   clk, rst  : clock, asynchronous active-low reset (all counters to 0)
//   inc_i     : register receiving a new in-flight write (issue)
//   dec_i     : register whose write retires this cycle (writeback)
//   pend_o    : registered pending count per register (pend_o[0] is always 0)
//   sat_o     : counter at its maximum; another write to it must wait
module rv_scbd_cnt #(
  parameter int NREG   = rv_pkg::NREG,
  parameter int PEND_W = rv_pkg::PEND_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  rv_pkg::reg_upd_t             inc_i,
  input  rv_pkg::reg_upd_t             dec_i,
  output logic [NREG-1:0][PEND_W-1:0]  pend_o,
  output logic [NREG-1:0]              sat_o
);
  import rv_pkg::*;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // x0 is hardwired zero, so it can never carry a pending write.
  assign pend_o[0] = '0;
  assign sat_o[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic              hit_inc, hit_dec;

    assign hit_inc = inc_i.vld && (inc_i.idx == IDX_W'(r));
    assign hit_dec = dec_i.vld && (dec_i.idx == IDX_W'(r));

    // Simultaneous issue and retire on the same register cancel out.
    // A retire against an empty counter is dropped rather than wrapping.
    always_comb begin
      cnt_d = cnt_q;
      if (hit_inc && !hit_dec && cnt_q != PEND_MAX)
        cnt_d = cnt_q + 1'b1;
      else if (hit_dec && !hit_inc && cnt_q != '0)
        cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end

    assign pend_o[r] = cnt_q;
    assign sat_o[r]  = (cnt_q == PEND_MAX);
  end

endmodule

// File: rtl/rv_issue_ctrl.sv
// In-order issue controller: holds the ID-stage instruction on RAW or
// pending-write saturation hazards, serialises multi-cycle mul/div/rem,
// and drains outstanding writes after ebreak before halting.
//   clk, rst               : clock, asynchronous active-low reset
//   id_valid / id_ready    : ID instruction present / accepted this cycle
//   id_rs1/rs2/rd, id_use_*: operand indices and which sources are read
//   id_rf_we, id_long,
//   id_ebreak              : writes rd / multi-cycle op / ebreak
//   ex_valid / ex_ready    : issue to EXU / EXU can accept
//   long_done              : multi-cycle unit finished (pulse)
//   wb_we, wb_rd           : register write retiring this cycle
//   stall_raw              : issue blocked by hazard
//   halted                 : ebreak drained, core stopped
//   issue_cnt              : free-running issued-instruction count
module rv_issue_ctrl #(
  parameter int NREG   = rv_pkg::NREG,
  parameter int PEND_W = rv_pkg::PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [rv_pkg::IDX_W-1:0] id_rs1,
  input  logic [rv_pkg::IDX_W-1:0] id_rs2,
  input  logic [rv_pkg::IDX_W-1:0] id_rd,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic                     id_rf_we,
  input  logic                     id_long,
  input  logic                     id_ebreak,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  input  logic                     long_done,
  input  logic                     wb_we,
  input  logic [rv_pkg::IDX_W-1:0] wb_rd,
  output logic                     stall_raw,
  output logic                     halted,
  output logic [31:0]              issue_cnt
);
  import rv_pkg::*;

  state_e                      state_q, state_d;
  logic [NREG-1:0][PEND_W-1:0] pend;
  logic [NREG-1:0]             busy, sat;
  logic                        hazard, in_run, issue, all_idle;
  reg_upd_t                    inc, dec;
  logic [31:0]                 issue_cnt_q, issue_cnt_d;

  rv_scbd_cnt #(.NREG(NREG), .PEND_W(PEND_W)) u_scbd (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (inc),
    .dec_i  (dec),
    .pend_o (pend),
    .sat_o  (sat)
  );

  always_comb begin
    busy = '0;
    for (int i = 0; i < NREG; i++) busy[i] = |pend[i];
  end

  // Hazards look only at registered counts: a write retiring this cycle
  // releases its consumer on the following cycle, never the same one.
  assign hazard = (id_use_rs1 & busy[id_rs1])
                | (id_use_rs2 & busy[id_rs2])
                | (id_rf_we & (id_rd != '0) & sat[id_rd]);

  assign in_run   = (state_q == ST_RUN);
  assign issue    = in_run & id_valid & ex_ready & ~hazard;
  assign all_idle = ~|busy;

  assign inc = '{vld: issue & id_rf_we & (id_rd != '0), idx: id_rd};
  assign dec = '{vld: wb_we & (wb_rd != '0),            idx: wb_rd};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Next-state logic; ebreak wins over id_long when both are flagged.
  // DRAIN waits on the registered counters, so writes added by the ebreak
  // issue cycle itself are already visible when the check is made.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (issue && id_ebreak)    state_d = ST_DRAIN;
        else if (issue && id_long) state_d = ST_LONGWAIT;
      end
      ST_LONGWAIT: if (long_done) state_d = ST_RUN;
      ST_DRAIN:    if (all_idle)  state_d = ST_HALT;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    ex_valid  = issue;
    id_ready  = issue;
    stall_raw = in_run & id_valid & hazard;
    halted    = (state_q == ST_HALT);
  end

  assign issue_cnt_d = issue ? issue_cnt_q + 32'd1 : issue_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) issue_cnt_q <= '0;
    else      issue_cnt_q <= issue_cnt_d;
  end

  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_rv_issue_ctrl.sv
module tb_rv_issue_ctrl;

  localparam int MAXP = 3;
  localparam int M_RUN = 0, M_LONG = 1, M_DRAIN = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_rf_we = 0;
  logic        id_long = 0, id_ebreak = 0, ex_ready = 0, long_done = 0, wb_we = 0;
  logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0, wb_rd = 0;
  logic        id_ready, ex_valid, stall_raw, halted;
  logic [31:0] issue_cnt;

  rv_issue_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rf_we(id_rf_we),
    .id_long(id_long), .id_ebreak(id_ebreak), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .long_done(long_done), .wb_we(wb_we), .wb_rd(wb_rd),
    .stall_raw(stall_raw), .halted(halted), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rstn, valid, u1, u2, we, lng, ebk, exr, ld, wbwe;
    bit [4:0] rs1, rs2, rd, wbrd;
  } stim_t;

  typedef struct packed {
    logic            ev, st, hl;
    logic [31:0]     cnt;
    logic [31:0][1:0] pend;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;

  // Reference model: plain per-register in-flight counts and a mode number.
  int          mpend[32];
  int          mode;
  logic [31:0] mcnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the
  // oldest expectation pushed by the driver.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid",  64'(ex_valid),  64'(e.ev));
        chk("id_ready",  64'(id_ready),  64'(e.ev));
        chk("stall_raw", 64'(stall_raw), 64'(e.st));
        chk("halted",    64'(halted),    64'(e.hl));
        chk("issue_cnt", 64'(issue_cnt), 64'(e.cnt));
        chk("pend",      64'(dut.pend),  64'(e.pend));
      end
    end
  end

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    s.rstn = 1'b1;
    s.exr  = 1'b1;
    return s;
  endfunction

  function automatic stim_t ins(int rd, bit we, int rs1, bit u1, int rs2, bit u2);
    stim_t s;
    s = nop();
    s.valid = 1'b1;
    s.rd  = 5'(rd);  s.we = we;
    s.rs1 = 5'(rs1); s.u1 = u1;
    s.rs2 = 5'(rs2); s.u2 = u2;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   haz, iss, allz, inc_hit;
    @(posedge clk); #1;
    rst = s.rstn;
    id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_rf_we = s.we;
    id_long = s.lng; id_ebreak = s.ebk; ex_ready = s.exr;
    long_done = s.ld; wb_we = s.wbwe; wb_rd = s.wbrd;
    if (!s.rstn) begin
      foreach (mpend[i]) mpend[i] = 0;
      mode = M_RUN;
      mcnt = '0;
    end
    haz = (s.u1 && mpend[s.rs1] > 0) || (s.u2 && mpend[s.rs2] > 0) ||
          (s.we && s.rd != 0 && mpend[s.rd] == MAXP);
    iss = (mode == M_RUN) && s.valid && s.exr && !haz;
    e.ev  = iss;
    e.st  = (mode == M_RUN) && s.valid && haz;
    e.hl  = (mode == M_HALT);
    e.cnt = mcnt;
    for (int i = 0; i < 32; i++) e.pend[i] = 2'(mpend[i]);
    q.push_back(e);
    if (s.rstn) begin
      allz = 1'b1;
      foreach (mpend[i]) if (mpend[i] != 0) allz = 1'b0;
      inc_hit = iss && s.we && s.rd != 0;
      if (!(inc_hit && s.wbwe && s.wbrd == s.rd)) begin
        if (inc_hit) mpend[s.rd]++;
        if (s.wbwe && s.wbrd != 0 && mpend[s.wbrd] > 0) mpend[s.wbrd]--;
      end
      case (mode)
        M_RUN:   if (iss && s.ebk) mode = M_DRAIN;
                 else if (iss && s.lng) mode = M_LONG;
        M_LONG:  if (s.ld) mode = M_RUN;
        M_DRAIN: if (allz) mode = M_HALT;
        default: ;
      endcase
      if (iss) mcnt = mcnt + 32'd1;
    end
  endtask

  task automatic do_reset();
    stim_t s;
    s = nop();
    s.rstn = 1'b0;
    step(s);
    step(s);
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s = nop();
    s.valid = ($urandom_range(0, 3) != 0);
    s.rs1 = 5'($urandom_range(0, 7)); s.u1 = 1'($urandom);
    s.rs2 = 5'($urandom_range(0, 7)); s.u2 = 1'($urandom);
    s.rd  = 5'($urandom_range(0, 7)); s.we = ($urandom_range(0, 3) != 0);
    s.lng = ($urandom_range(0, 9) == 0);
    s.ebk = ($urandom_range(0, 59) == 0);
    s.exr = ($urandom_range(0, 4) != 0);
    s.ld  = ($urandom_range(0, 5) == 0);
    s.wbwe = 1'($urandom);
    s.wbrd = 5'($urandom_range(0, 7));
    s.rstn = ($urandom_range(0, 199) != 0);
    if (mode == M_HALT && $urandom_range(0, 3) == 0) s.rstn = 1'b0;
    return s;
  endfunction

  initial begin
    stim_t s;
    foreach (mpend[i]) mpend[i] = 0;
    mode = M_RUN;
    mcnt = '0;

    // Reset state, then addi x5 followed by dependent add x6,x5,x1.
    do_reset();
    step(ins(5, 1, 0, 1, 0, 0));
    repeat (3) step(ins(6, 1, 5, 1, 1, 1));
    s = ins(6, 1, 5, 1, 1, 1); s.wbwe = 1; s.wbrd = 5;
    step(s);
    step(ins(6, 1, 5, 1, 1, 1));
    step(nop());

    // Three writes to x7 saturate it; the fourth waits for one retire.
    do_reset();
    repeat (3) step(ins(7, 1, 0, 0, 0, 0));
    repeat (2) step(ins(7, 1, 0, 0, 0, 0));
    s = ins(7, 1, 0, 0, 0, 0); s.wbwe = 1; s.wbrd = 7;
    step(s);
    step(ins(7, 1, 0, 0, 0, 0));
    step(nop());

    // mul x3 blocks issue until long_done.
    do_reset();
    s = ins(3, 1, 1, 1, 2, 1); s.lng = 1;
    step(s);
    repeat (3) step(ins(8, 1, 1, 1, 0, 0));
    s = ins(8, 1, 1, 1, 0, 0); s.ld = 1;
    step(s);
    step(ins(8, 1, 1, 1, 0, 0));
    step(nop());

    // ebreak with x4 outstanding drains, then halts and stays halted.
    do_reset();
    step(ins(4, 1, 0, 0, 0, 0));
    s = ins(0, 0, 0, 0, 0, 0); s.ebk = 1;
    step(s);
    repeat (2) step(ins(1, 1, 0, 0, 0, 0));
    s = ins(1, 1, 0, 0, 0, 0); s.wbwe = 1; s.wbrd = 4;
    step(s);
    repeat (4) step(ins(1, 1, 0, 0, 0, 0));

    // Same-cycle issue and retire on x9; writes to x0 never stall.
    do_reset();
    step(ins(9, 1, 0, 0, 0, 0));
    s = ins(9, 1, 0, 0, 0, 0); s.wbwe = 1; s.wbrd = 9;
    step(s);
    step(nop());
    repeat (6) step(ins(0, 1, 0, 1, 0, 1));
    s = nop(); s.wbwe = 1; s.wbrd = 0;
    step(s);

    // Reset while in LONGWAIT with pending writes.
    do_reset();
    step(ins(10, 1, 0, 0, 0, 0));
    step(ins(11, 1, 0, 0, 0, 0));
    s = ins(12, 1, 0, 0, 0, 0); s.lng = 1;
    step(s);
    step(ins(13, 1, 0, 0, 0, 0));
    s = ins(13, 1, 0, 0, 0, 0); s.rstn = 0;
    step(s);
    step(ins(13, 1, 0, 0, 0, 0));
    step(nop());

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) step(rnd());

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule
